ysyx_22040237_ifu: RTL

Instruction fetch unit for the NPC core: owns the architectural PC, issues one 32-bit fetch at a time to instruction memory over a valid/ready request + valid response interface, and presents each fetched instruction with its PC to the decode stage through a one-entry output buffer under valid/ready. Branch/jump redirects from the execute stage override the PC and discard any in-flight or buffered instruction.

---
 rtl/ysyx_22040237_ifu_pkg.sv | 29 ++
 rtl/ysyx_22040237_ifu.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_ifu_pkg.sv
// ============================================================================
// Module  : ysyx_22040237_ifu_pkg
// Brief   : Shared widths, reset PC, IFU state encodings and invalid-inst word
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef ysyx_22040237_REG_WIDTH
`define ysyx_22040237_REG_WIDTH 64
`endif

package ysyx_22040237_ifu_pkg;

    localparam int unsigned c_reg_width    = `ysyx_22040237_REG_WIDTH;
    localparam logic [63:0] c_reset_pc     = 64'h0000_0000_8000_0000;
    // IDU treats an all-zero word as an invalid instruction.
    localparam logic [31:0] c_inst_invalid = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_22040237_ifu.sv
// ============================================================================
// Module  : ysyx_22040237_ifu
// Brief   : Fetch unit: owns PC, single outstanding fetch, one-entry IDU buffer
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ysyx_22040237_ifu
    import ysyx_22040237_ifu_pkg::*;
#(
    parameter int              XLEN     = c_reg_width,
    parameter logic [XLEN-1:0] RESET_PC = c_reset_pc[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_rsp_valid_i,
    input  logic [31:0]     mem_rsp_data_i,
    input  logic            mem_rsp_err_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fault_o
);

    ifu_state_e      r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_pc_out, w_pc_out_nxt;
    logic [31:0]     r_inst, w_inst_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_fault, w_fault_nxt;
    logic            w_misaligned;
    logic            w_req_fire;
    logic            w_outstanding;

    // Request valid is a pure decode of registered state, held low while reset is asserted.
    assign w_misaligned    = |r_pc[1:0];
    assign mem_req_valid_o = rst && (r_state == S_REQ) && !w_misaligned;
    assign mem_req_addr_o  = r_pc;
    assign w_req_fire      = mem_req_valid_o && mem_req_ready_i;

    // A memory response is still owed after this cycle; a redirect must then drain it.
    assign w_outstanding = ((r_state == S_WAIT) && !mem_rsp_valid_i) ||
                           ((r_state == S_REQ)  && w_req_fire)       ||
                           ((r_state == S_DROP) && !mem_rsp_valid_i);

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_valid_nxt  = r_valid;
        w_inst_nxt   = r_inst;
        w_pc_out_nxt = r_pc_out;
        w_fault_nxt  = r_fault;

        case (r_state)
            S_REQ: begin
                if (w_misaligned) begin
                    w_valid_nxt  = 1'b1;
                    w_inst_nxt   = c_inst_invalid;
                    w_pc_out_nxt = r_pc;
                    w_fault_nxt  = 1'b1;
                    w_state_nxt  = S_HOLD;
                end else if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid_i) begin
                    w_valid_nxt  = 1'b1;
                    w_inst_nxt   = mem_rsp_data_i;
                    w_pc_out_nxt = r_pc;
                    w_fault_nxt  = mem_rsp_err_i;
                    w_state_nxt  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ready_i) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = r_pc + XLEN'(4);
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (mem_rsp_valid_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase

        // Redirect overrides everything above, including a same-cycle consume.
        if (redirect_i) begin
            w_pc_nxt    = redirect_pc_i;
            w_valid_nxt = 1'b0;
            w_state_nxt = w_outstanding ? S_DROP : S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_inst   <= '0;
            r_pc_out <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_valid  <= w_valid_nxt;
            r_inst   <= w_inst_nxt;
            r_pc_out <= w_pc_out_nxt;
            r_fault  <= w_fault_nxt;
        end
    end

    assign valid_o = r_valid;
    assign inst_o  = r_inst;
    assign pc_o    = r_pc_out;
    assign fault_o = r_fault;

endmodule

`default_nettype wire
